// File: rtl/game_flow_ctrl.sv
// Screen sequencer: title -> play -> end -> title, driving the ROM drawer and muxing the VGA write port.
// Optional macro GAME_FLOW_END_TIMEOUT_EN: auto-return from the end screen after END_TIMEOUT_CYCLES.
module game_flow_ctrl #(
  parameter int GAME_RST_CYCLES    = 4,
  parameter int END_TIMEOUT_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_start_n,
  input  logic       game_over,
  input  logic       screen_done,
  input  logic [8:0] screen_x,
  input  logic [7:0] screen_y,
  input  logic [2:0] screen_colour,
  input  logic [8:0] game_x,
  input  logic [7:0] game_y,
  input  logic [2:0] game_colour,
  input  logic       game_plot,
  output logic       display_title,
  output logic       display_end,
  output logic       plot_screen,
  output logic       game_run,
  output logic       game_resetn,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    S_TITLE_DRAW = 3'd0,
    S_TITLE_WAIT = 3'd1,
    S_GAME_RST   = 3'd2,
    S_PLAY       = 3'd3,
    S_END_DRAW   = 3'd4,
    S_END_WAIT   = 3'd5
  } state_t;

  localparam int RW = (GAME_RST_CYCLES > 1) ? $clog2(GAME_RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(GAME_RST_CYCLES - 1);

  state_t state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic ksync1_q, ksync2_q, kprev_q;
  logic start_pulse;
  logic [8:0] vga_x_q, vga_x_d;
  logic [7:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;

`ifdef GAME_FLOW_END_TIMEOUT_EN
  localparam logic [27:0] TO_LAST = 28'(END_TIMEOUT_CYCLES - 1);
  logic [27:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |END_TIMEOUT_CYCLES;
`endif

  // One pulse per press: falling edge of the synchronised (active-low) key.
  assign start_pulse = kprev_q & ~ksync2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_TITLE_DRAW;
      rst_cnt_q    <= '0;
      ksync1_q     <= 1'b1;
      ksync2_q     <= 1'b1;
      kprev_q      <= 1'b1;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
`ifdef GAME_FLOW_END_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      ksync1_q     <= key_start_n;
      ksync2_q     <= ksync1_q;
      kprev_q      <= ksync2_q;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
`ifdef GAME_FLOW_END_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
`ifdef GAME_FLOW_END_TIMEOUT_EN
    to_cnt_d  = '0;
`endif
    case (state_q)
      S_TITLE_DRAW: if (screen_done) state_d = S_TITLE_WAIT;
      S_TITLE_WAIT: if (start_pulse) state_d = S_GAME_RST;
      S_GAME_RST: begin
        rst_cnt_d = rst_cnt_q + 1'b1;
        if (rst_cnt_q == RST_LAST) state_d = S_PLAY;
      end
      S_PLAY:       if (game_over) state_d = S_END_DRAW;
      S_END_DRAW:   if (screen_done) state_d = S_END_WAIT;
      S_END_WAIT: begin
`ifdef GAME_FLOW_END_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 1'b1;
        if (start_pulse || to_cnt_q == TO_LAST) state_d = S_TITLE_DRAW;
`else
        if (start_pulse) state_d = S_TITLE_DRAW;
`endif
      end
      default:      state_d = S_TITLE_DRAW;
    endcase
  end

  always_comb begin
    display_title = 1'b0;
    display_end   = 1'b0;
    plot_screen   = 1'b0;
    game_run      = 1'b0;
    game_resetn   = 1'b0;
    case (state_q)
      S_TITLE_DRAW: begin display_title = 1'b1; plot_screen = 1'b1; end
      S_TITLE_WAIT: display_title = 1'b1;
      S_PLAY:       begin game_run = 1'b1; game_resetn = 1'b1; end
      S_END_DRAW:   begin display_end = 1'b1; plot_screen = 1'b1; end
      S_END_WAIT:   display_end = 1'b1;
      default:      ;
    endcase
  end

  // Drawer pre-roll coordinates lie off-screen; gate them out of the write strobe.
  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    if (state_q == S_TITLE_DRAW || state_q == S_END_DRAW) begin
      vga_x_d      = screen_x;
      vga_y_d      = screen_y;
      vga_colour_d = screen_colour;
      vga_plot_d   = plot_screen & (screen_x < 9'd320) & (screen_y < 8'd240);
    end else if (state_q == S_PLAY) begin
      vga_x_d      = game_x;
      vga_y_d      = game_y;
      vga_colour_d = game_colour;
      vga_plot_d   = game_plot;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; expectations queued at drive time, popped at compare.
module tb_game_flow_ctrl;
  logic       clk = 1'b0;
  logic       resetn, key_start_n, game_over, screen_done, game_plot;
  logic [8:0] screen_x, game_x, vga_x;
  logic [7:0] screen_y, game_y, vga_y;
  logic [2:0] screen_colour, game_colour, vga_colour, state_dbg;
  logic       display_title, display_end, plot_screen, game_run, game_resetn, vga_plot;

  int n_cmp = 0;
  int n_bad = 0;
  int     exp_q[$];
  string  tag_q[$];

  game_flow_ctrl #(.GAME_RST_CYCLES(4), .END_TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .key_start_n(key_start_n), .game_over(game_over),
    .screen_done(screen_done), .screen_x(screen_x), .screen_y(screen_y),
    .screen_colour(screen_colour), .game_x(game_x), .game_y(game_y),
    .game_colour(game_colour), .game_plot(game_plot), .display_title(display_title),
    .display_end(display_end), .plot_screen(plot_screen), .game_run(game_run),
    .game_resetn(game_resetn), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input int exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_cmp(input int obs);
    string tag;
    int    exp;
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n2, n5, seen3, ok;
    resetn = 1'b0; key_start_n = 1'b1; game_over = 1'b0; screen_done = 1'b0;
    screen_x = 9'd10; screen_y = 8'd20; screen_colour = 3'd5;
    game_x = '0; game_y = '0; game_colour = '0; game_plot = 1'b0;
    tick(); tick();
    sb_push("rst_state", 0);   sb_cmp(state_dbg);
    sb_push("rst_vga_plot", 0); sb_cmp(vga_plot);
    sb_push("rst_vga_x", 0);   sb_cmp(vga_x);
    sb_push("rst_game_resetn", 0); sb_cmp(game_resetn);
    resetn = 1'b1;

    // Title draw for cycles 0..20, done on cycle 20.
    ok = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) screen_x = 9'd509;
      if (c == 6) begin screen_x = 9'd10; screen_y = 8'd240; end
      if (c == 7) screen_y = 8'd20;
      tick();
      if (!(display_title && plot_screen && state_dbg == 3'd0)) ok = 0;
      if (c == 3) begin sb_push("title_vga_plot", 1); sb_cmp(vga_plot);
                        sb_push("title_vga_x", 10);  sb_cmp(vga_x);
                        sb_push("title_vga_col", 5); sb_cmp(vga_colour); end
      if (c == 5) begin sb_push("x509_plot", 0); sb_cmp(vga_plot); end
      if (c == 6) begin sb_push("y240_plot", 0); sb_cmp(vga_plot); end
    end
    sb_push("title_hold", 1); sb_cmp(ok);
    screen_done = 1'b1;
    tick();
    screen_done = 1'b0;
    sb_push("title_wait_state", 1); sb_cmp(state_dbg);
    sb_push("title_wait_plot_screen", 0); sb_cmp(plot_screen);
    sb_push("title_wait_display_title", 1); sb_cmp(display_title);
    tick();
    sb_push("title_wait_vga_plot", 0); sb_cmp(vga_plot);

    // Start press held 10 cycles.
    n2 = 0; seen3 = 0; ok = 1;
    for (int i = 0; i < 30; i++) begin
      key_start_n = (i < 10) ? 1'b0 : 1'b1;
      tick();
      if (state_dbg == 3'd2) begin n2++; if (game_resetn !== 1'b0) ok = 0; end
      if (state_dbg == 3'd3) seen3 = 1;
    end
    sb_push("game_rst_cycles", 4); sb_cmp(n2);
    sb_push("game_rst_low", 1);    sb_cmp(ok);
    sb_push("reached_play", 1);    sb_cmp(seen3);
    sb_push("play_state_held", 3); sb_cmp(state_dbg);
    sb_push("game_run", 1);        sb_cmp(game_run);
    sb_push("game_resetn_play", 1); sb_cmp(game_resetn);

    // Game pixel passthrough.
    game_plot = 1'b1; game_x = 9'd100; game_y = 8'd50; game_colour = 3'b100;
    tick();
    sb_push("play_vga_x", 100); sb_cmp(vga_x);
    sb_push("play_vga_y", 50);  sb_cmp(vga_y);
    sb_push("play_vga_col", 4); sb_cmp(vga_colour);
    sb_push("play_vga_plot", 1); sb_cmp(vga_plot);
    game_plot = 1'b0;
    tick();
    sb_push("play_vga_plot_off", 0); sb_cmp(vga_plot);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    sb_push("end_draw_state", 4); sb_cmp(state_dbg);
    sb_push("end_display", 1);    sb_cmp(display_end);
    sb_push("end_plot_screen", 1); sb_cmp(plot_screen);

    // Pre-roll X suppressed, on-screen X written.
    screen_x = 9'd509; screen_y = 8'd0; screen_colour = 3'd2;
    tick();
    sb_push("end_x509_plot", 0); sb_cmp(vga_plot);
    screen_x = 9'd0;
    tick();
    sb_push("end_x0_plot", 1); sb_cmp(vga_plot);
    sb_push("end_x0_vga_x", 0); sb_cmp(vga_x);
    screen_done = 1'b1;
    tick();
    screen_done = 1'b0;
    sb_push("end_wait_state", 5); sb_cmp(state_dbg);

    // End wait: game_over ignored; timeout only with the macro.
    game_over = 1'b1;
    n5 = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_dbg == 3'd5) n5++; else break;
    end
    game_over = 1'b0;
    sb_push("end_wait_vga_plot", 0); sb_cmp(vga_plot);
`ifdef GAME_FLOW_END_TIMEOUT_EN
    sb_push("end_wait_cycles", 8); sb_cmp(n5);
    sb_push("timeout_to_title", 0); sb_cmp(state_dbg);
`else
    sb_push("end_wait_cycles", 21); sb_cmp(n5);
    key_start_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (state_dbg == 3'd0) break;
    end
    sb_push("start_to_title", 0); sb_cmp(state_dbg);
`endif

    // Press during title draw is discarded.
    key_start_n = 1'b1;
    tick(); tick(); tick(); tick();
    key_start_n = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    key_start_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    sb_push("press_in_draw_state", 0); sb_cmp(state_dbg);
    screen_done = 1'b1;
    tick();
    screen_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    sb_push("no_skip_to_rst", 1); sb_cmp(state_dbg);

    // Mid-operation reset.
    key_start_n = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    sb_push("pre_reset_play", 3); sb_cmp(state_dbg);
    resetn = 1'b0;
    tick();
    sb_push("midrst_state", 0);      sb_cmp(state_dbg);
    sb_push("midrst_vga_plot", 0);   sb_cmp(vga_plot);
    sb_push("midrst_game_resetn", 0); sb_cmp(game_resetn);
    resetn = 1'b1; key_start_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
